// File: rtl/mux_onehot_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : mux_onehot_pipe
//  Purpose  : N-channel, WIDTH-bit one-hot-select multiplexer with a
//             registered output stage, valid/ready handshake and a two-entry
//             skid buffer (OUT + SKID) for full throughput under backpressure.
//  Build    : define MUX_SEL_CHECK_EN to make a multi-hot select yield 0 and
//             raise the sticky sel_err flag. Without it, a multi-hot select
//             yields the OR of the selected channels, and sel_err is tied to 0.
//  Ports    : clk       - rising-edge clock
//             reset     - synchronous active-high reset
//             in_valid  - input beat valid
//             in_ready  - block can accept a beat (registered)
//             sel       - one-hot select, bit k selects channel k
//             d         - channel k at d[k*WIDTH +: WIDTH]
//             out_valid - y holds a valid result
//             out_ready - downstream consumes y
//             y         - selected word
//             err_clr   - clears sel_err (check build only)
//             sel_err   - sticky invalid-select flag
//  Revision : 1.0 - initial release
// ============================================================================
module mux_onehot_pipe #(
  parameter int WIDTH = 32,
  parameter int N     = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       sel,
  input  logic [N*WIDTH-1:0] d,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   y,
  input  logic               err_clr,
  output logic               sel_err
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q,  skid_data_d;

  logic             w_accept;
  logic             w_consume;
  logic [WIDTH-1:0] w_andor;
  logic [WIDTH-1:0] w_result;

  // AND-OR mux across all channels; sel == 0 naturally gives 0.
  always_comb begin
    w_andor = '0;
    for (int k = 0; k < N; k++) begin
      w_andor = w_andor | ({WIDTH{sel[k]}} & d[k*WIDTH +: WIDTH]);
    end
  end

`ifdef MUX_SEL_CHECK_EN
  logic w_multi;
  logic sel_err_q, sel_err_d;

  // More than one bit set: clearing the lowest set bit leaves something.
  assign w_multi  = |(sel & (sel - {{(N-1){1'b0}}, 1'b1}));
  assign w_result = w_multi ? '0 : w_andor;

  // Set has priority over clear when both happen in the same cycle.
  always_comb begin
    sel_err_d = sel_err_q;
    if (w_accept && w_multi) begin
      sel_err_d = 1'b1;
    end else if (err_clr) begin
      sel_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= sel_err_d;
    end
  end

  assign sel_err = sel_err_q;
`else
  logic w_unused_err_clr;

  assign w_unused_err_clr = err_clr;
  assign w_result         = w_andor;
  assign sel_err          = 1'b0;
`endif

  // in_ready depends only on the SKID register, never on out_ready.
  assign w_accept  = in_valid && !skid_valid_q;
  assign w_consume = out_valid_q && out_ready;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;

    if (w_consume && skid_valid_q) begin
      // Drain SKID into OUT; no accept can coincide since in_ready is low.
      out_valid_d  = 1'b1;
      out_data_d   = skid_data_q;
      skid_valid_d = 1'b0;
    end else if (w_accept) begin
      if (!out_valid_q || w_consume) begin
        out_valid_d = 1'b1;
        out_data_d  = w_result;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = w_result;
      end
    end else if (w_consume) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign in_ready  = !skid_valid_q;
  assign out_valid = out_valid_q;
  assign y         = out_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_onehot_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mux_onehot_pipe
//  Purpose  : Self-checking bench for mux_onehot_pipe (N=5, WIDTH=32).
//             Driver pushes the expected word on every accept; a monitor
//             pops and compares on every consumed output beat.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mux_onehot_pipe;

  localparam int W = 32;
  localparam int N = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   sel;
  logic [N*W-1:0] d;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   y;
  logic           err_clr;
  logic           sel_err;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];

  mux_onehot_pipe #(.WIDTH(W), .N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .sel      (sel),
    .d        (d),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .err_clr  (err_clr),
    .sel_err  (sel_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a beat is consumed at the next rising edge when valid & ready.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_beat: got %h expected none", y);
      end else begin
        logic [W-1:0] e;
        e = exp_q.pop_front();
        if (y !== e) begin
          fails++;
          $display("FAIL beat_data: got %h expected %h", y, e);
        end
      end
    end
  end

  function automatic logic [N*W-1:0] ramp_d();
    logic [N*W-1:0] v;
    for (int k = 0; k < N; k++) v[k*W +: W] = 32'h1000_0000 + k;
    return v;
  endfunction

  // Drive one beat, wait (bounded) for in_ready, then let the edge accept it.
  task automatic send(input logic [N-1:0] s, input logic [N*W-1:0] dd, input logic [W-1:0] e);
    int cnt;
    in_valid = 1'b1;
    sel      = s;
    d        = dd;
    cnt      = 0;
    while (!in_ready && cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end else begin
      exp_q.push_back(e);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  logic [N*W-1:0] dm;
  logic [W-1:0]   a_w, b_w, c_w;

  initial begin
    reset = 1'b1; in_valid = 1'b0; sel = '0; d = '0;
    out_ready = 1'b0; err_clr = 1'b0;
    cycles(3);
    reset = 1'b0;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_y", y, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_sel_err", {31'd0, sel_err}, 32'd0);

    // Back-to-back one-hot beats with the sink always ready.
    out_ready = 1'b1;
    send(5'b00001, ramp_d(), 32'h1000_0000);
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("lat_y", y, 32'h1000_0000);
    send(5'b00100, ramp_d(), 32'h1000_0002);
    send(5'b10000, ramp_d(), 32'h1000_0004);
    cycles(2);
    check("t1_drained", exp_q.size(), 32'd0);

    // Zero select gives zero and never flags.
    send(5'b00000, ramp_d(), 32'h0);
    cycles(2);
    check("zero_sel_err", {31'd0, sel_err}, 32'd0);

    // Backpressure: A and B absorbed, C held off.
    out_ready = 1'b0;
    a_w = 32'h1000_0001; b_w = 32'h1000_0003; c_w = 32'h1000_0000;
    send(5'b00010, ramp_d(), a_w);
    send(5'b01000, ramp_d(), b_w);
    check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
    in_valid = 1'b1; sel = 5'b00001; d = ramp_d();
    cycles(3);
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    check("bp_hold_y", y, a_w);
    check("bp_still_blocked", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    send(5'b00001, ramp_d(), c_w);
    cycles(3);
    check("bp_drained", exp_q.size(), 32'd0);

    // Multi-hot select.
    dm = '0; dm[0*W +: W] = 32'h0F; dm[1*W +: W] = 32'hF0;
`ifdef MUX_SEL_CHECK_EN
    send(5'b00011, dm, 32'h0);
    cycles(2);
    check("mh_err_set", {31'd0, sel_err}, 32'd1);
    cycles(2);
    check("mh_err_sticky", {31'd0, sel_err}, 32'd1);
    err_clr = 1'b1;
    send(5'b00011, dm, 32'h0);
    err_clr = 1'b0;
    check("mh_set_wins", {31'd0, sel_err}, 32'd1);
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    check("mh_err_clr", {31'd0, sel_err}, 32'd0);
`else
    send(5'b00011, dm, 32'hFF);
    cycles(2);
    check("mh_no_err", {31'd0, sel_err}, 32'd0);
    err_clr = 1'b1;
    cycles(1);
    err_clr = 1'b0;
    check("mh_err_tied", {31'd0, sel_err}, 32'd0);
`endif
    cycles(2);

    // Reset with OUT and SKID both full discards everything.
    out_ready = 1'b0;
    send(5'b00100, ramp_d(), 32'h1000_0002);
    send(5'b01000, ramp_d(), 32'h1000_0003);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1;
    exp_q.delete();
    cycles(1);
    reset = 1'b0;
    check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst2_y", y, 32'd0);
    check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst2_sel_err", {31'd0, sel_err}, 32'd0);
    out_ready = 1'b1;
    cycles(5);
    check("no_stale_valid", {31'd0, out_valid}, 32'd0);
    check("final_queue", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
